// File: rtl/adc_scan_avg.sv
// Purpose : autonomous ADC channel scanner; oversamples each slot 2^AVG_LOG2 times
//           and keeps the truncated average per slot in a small result bank.
// Latency : 3 cycles + ADC latency per sample; rd_data is 1 cycle after rd_addr.
// Backpressure: command held stable until command_ready; one command outstanding.
//
// Ports:
//   clock_clk, reset_sink_reset      : clock, synchronous active-high reset
//   enable, continuous               : scan control (level / single-pass on rising edge)
//   command_*                        : Avalon-ST command to the ADC core (SOP=EOP=valid)
//   response_*                       : Avalon-ST sample returned by the ADC core
//   rd_addr, rd_data                 : result bank read port (out of range reads 0)
//   busy, scan_done, err             : scan status, end-of-pass pulse, sticky error
module adc_scan_avg #(
    parameter int                     NUM_CH   = 4,
    parameter int                     CH_W     = 5,
    parameter int                     DATA_W   = 12,
    parameter int                     AVG_LOG2 = 2,
    parameter logic [NUM_CH*CH_W-1:0] CH_MAP   = {5'd4, 5'd3, 5'd2, 5'd1},
    parameter int                     TIMEOUT  = 1023
) (
    input  logic              clock_clk,
    input  logic              reset_sink_reset,
    input  logic              enable,
    input  logic              continuous,
    output logic              command_valid,
    output logic [CH_W-1:0]   command_channel,
    output logic              command_startofpacket,
    output logic              command_endofpacket,
    input  logic              command_ready,
    input  logic              response_valid,
    input  logic [CH_W-1:0]   response_channel,
    input  logic [DATA_W-1:0] response_data,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              scan_done,
    output logic              err
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(1) << AVG_LOG2;
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);
    localparam logic [3:0]       SLOT_LAST = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

    state_t            state_q;
    logic [3:0]        slot_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              en_q;
    logic              rst_win_q;
    logic              cmd_vld_q;
    logic [CH_W-1:0]   cmd_ch_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] res_q [NUM_CH];

    // Channel scanned by a slot; constant-index lookup keeps slot values
    // beyond NUM_CH-1 harmless.
    function automatic logic [CH_W-1:0] slot_ch(input logic [3:0] s);
        slot_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s == 4'(i)) slot_ch = CH_MAP[i*CH_W +: CH_W];
        end
    endfunction

    logic             start;
    logic             rsp_hit;
    logic             tmo_hit;
    logic             sample_done;
    logic [ACC_W-1:0] acc_add;
    logic [CNT_W-1:0] cnt_inc;

    // continuous mode is level-triggered; single-pass needs a fresh rising edge
    assign start       = enable && (continuous || !en_q);
    assign rsp_hit     = response_valid && (response_channel == slot_ch(slot_q));
    // a matching response in the timeout cycle wins over the timeout
    assign tmo_hit     = !rsp_hit && (tmo_q == TMO_MAX);
    assign sample_done = rsp_hit || tmo_hit;
    assign acc_add     = rsp_hit ? ACC_W'(response_data) : '0;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            tmo_q     <= '0;
            en_q      <= 1'b0;
            rst_win_q <= 1'b1;
            cmd_vld_q <= 1'b0;
            cmd_ch_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
        end else begin
            en_q      <= enable;
            rst_win_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    // a stale response landing right after reset is not an error
                    if (response_valid && !rst_win_q) err_q <= 1'b1;
                    if (start) begin
                        state_q   <= ISSUE;
                        busy_q    <= 1'b1;
                        cmd_vld_q <= 1'b1;
                        cmd_ch_q  <= slot_ch(4'd0);
                    end
                end
                ISSUE: begin
                    if (response_valid) err_q <= 1'b1;
                    if (command_ready) begin
                        cmd_vld_q <= 1'b0;
                        tmo_q     <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (response_valid && !rsp_hit) err_q <= 1'b1;
                    if (tmo_hit) err_q <= 1'b1;
                    if (sample_done) begin
                        acc_q <= acc_q + acc_add;
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_FULL) begin
                            state_q <= STORE;
                        end else begin
                            state_q   <= ISSUE;
                            cmd_vld_q <= 1'b1;
                            cmd_ch_q  <= slot_ch(slot_q);
                        end
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                STORE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (slot_q == 4'(i)) res_q[i] <= DATA_W'(acc_q >> AVG_LOG2);
                    end
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (slot_q == SLOT_LAST) begin
                        done_q <= 1'b1;
                        slot_q <= '0;
                        if (continuous && enable) begin
                            state_q   <= ISSUE;
                            cmd_vld_q <= 1'b1;
                            cmd_ch_q  <= slot_ch(4'd0);
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (!enable) begin
                        // abandoned pass: next scan starts again from slot 0
                        slot_q  <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        slot_q    <= slot_q + 4'd1;
                        state_q   <= ISSUE;
                        cmd_vld_q <= 1'b1;
                        cmd_ch_q  <= slot_ch(slot_q + 4'd1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Registered read; a same-cycle STORE to the addressed slot returns the old value.
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_addr == 4'(i)) rd_data_q <= res_q[i];
            end
        end
    end

    assign command_valid         = cmd_vld_q;
    assign command_channel       = cmd_ch_q;
    assign command_startofpacket = cmd_vld_q;
    assign command_endofpacket   = cmd_vld_q;
    assign rd_data               = rd_data_q;
    assign busy                  = busy_q;
    assign scan_done             = done_q;
    assign err                   = err_q;

endmodule
